// File: rtl/f_next_pc.sv
// F-stage program counter and next-PC selector for the 5-stage MIPS pipeline.
// The PC register is redirected by D-stage jr/jalr, j/jal and taken branches.
// Otherwise it advances sequentially, and it holds while fetch is stalled.
// The instruction fetched alongside a D-stage redirect is the delay slot and
// always proceeds; nothing is flushed here.
// The PC also drives the instruction-memory word index and the range and
// alignment flags.
// Optional feature macro: F_BR_STAT_EN enables saturating branch statistics
// counters. When it is undefined, both counters read 0.

module f_next_pc #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_AW    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              F_en,
    input  logic [31:0]       D_PC,
    input  logic [15:0]       D_imm16,
    input  logic [25:0]       D_imm26,
    input  logic              Is_Branch,
    input  logic              B_jump,
    input  logic              Is_J,
    input  logic              Is_JR,
    input  logic [31:0]       D_RD1,
    output logic [31:0]       F_PC,
    output logic [31:0]       F_PC4,
    output logic [IM_AW-1:0]  F_IM_addr,
    output logic              F_oor,
    output logic              F_misalign,
    output logic [31:0]       br_cnt,
    output logic [31:0]       br_taken_cnt
);

    // Byte span of the instruction memory, one bit wider than the PC so the
    // range compare stays exact.
    localparam logic [32:0] IM_SPAN = 33'd4 << IM_AW;

    // Which source feeds the PC on the next edge.
    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_JR,
        SRC_J,
        SRC_BRANCH,
        SRC_SEQ
    } pcSrc_e;

    pcSrc_e      pcSrc;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] dPcPlus4;
    logic [31:0] branchOffset;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;
    logic [31:0] seqTarget;
    logic [31:0] imOffset;

    assign dPcPlus4     = D_PC + 32'd4;
    assign branchOffset = {{14{D_imm16[15]}}, D_imm16, 2'b00};
    assign branchTarget = dPcPlus4 + branchOffset;
    assign jumpTarget   = {dPcPlus4[31:28], D_imm26, 2'b00};
    assign seqTarget    = pc_q + 32'd4;

    // A stall freezes fetch and masks stale D-stage controls. Otherwise
    // jr outranks j, j outranks a taken branch, and sequential fetch is the
    // fallback.
    always_comb begin
        pcSrc = SRC_SEQ;
        if (!F_en) begin
            pcSrc = SRC_HOLD;
        end else if (Is_JR) begin
            pcSrc = SRC_JR;
        end else if (Is_J) begin
            pcSrc = SRC_J;
        end else if (B_jump) begin
            pcSrc = SRC_BRANCH;
        end
    end

    // Map the selected source onto the next PC value.
    always_comb begin
        pc_d = seqTarget;
        unique case (pcSrc)
            SRC_HOLD:   pc_d = pc_q;
            SRC_JR:     pc_d = D_RD1;
            SRC_J:      pc_d = jumpTarget;
            SRC_BRANCH: pc_d = branchTarget;
            SRC_SEQ:    pc_d = seqTarget;
            default:    pc_d = seqTarget;
        endcase
    end

    // PC register with synchronous reset to the instruction-memory base.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    // An address below the base wraps to a huge offset, so a single unsigned
    // compare covers both ends of the range.
    assign imOffset   = pc_q - PC_RESET;
    assign F_PC       = pc_q;
    assign F_PC4      = seqTarget;
    assign F_IM_addr  = imOffset[IM_AW+1:2];
    assign F_oor      = ({1'b0, imOffset} >= IM_SPAN);
    assign F_misalign = (pc_q[1:0] != 2'b00);

`ifdef F_BR_STAT_EN
    logic [31:0] brCnt_q;
    logic [31:0] brCnt_d;
    logic [31:0] brTakenCnt_q;
    logic [31:0] brTakenCnt_d;

    // Count every branch that leaves D while fetch is enabled, and count the
    // taken ones separately. Both counters stick at all-ones.
    always_comb begin
        brCnt_d      = brCnt_q;
        brTakenCnt_d = brTakenCnt_q;
        if (F_en && Is_Branch) begin
            if (brCnt_q != 32'hFFFF_FFFF) begin
                brCnt_d = brCnt_q + 32'd1;
            end
            if (B_jump && (brTakenCnt_q != 32'hFFFF_FFFF)) begin
                brTakenCnt_d = brTakenCnt_q + 32'd1;
            end
        end
    end

    // Statistics registers cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            brCnt_q      <= '0;
            brTakenCnt_q <= '0;
        end else begin
            brCnt_q      <= brCnt_d;
            brTakenCnt_q <= brTakenCnt_d;
        end
    end

    assign br_cnt       = brCnt_q;
    assign br_taken_cnt = brTakenCnt_q;
`else
    // Without statistics, Is_Branch has no consumer; it is parked on a sink
    // net so the port list stays the same in both builds.
    logic unusedIsBranch;
    assign unusedIsBranch = Is_Branch;
    assign br_cnt         = 32'd0;
    assign br_taken_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_f_next_pc.sv
// Testbench for f_next_pc.
// It runs a directed vector table first, then hand-written wrap and
// mid-run reset sequences, then randomized traffic. Every phase is checked
// against an arithmetic reference model of the fetch-PC rules.

module tb_f_next_pc;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int          IM_AW    = 12;

    logic              clk;
    logic              reset;
    logic              F_en;
    logic [31:0]       D_PC;
    logic [15:0]       D_imm16;
    logic [25:0]       D_imm26;
    logic              Is_Branch;
    logic              B_jump;
    logic              Is_J;
    logic              Is_JR;
    logic [31:0]       D_RD1;
    logic [31:0]       F_PC;
    logic [31:0]       F_PC4;
    logic [IM_AW-1:0]  F_IM_addr;
    logic              F_oor;
    logic              F_misalign;
    logic [31:0]       br_cnt;
    logic [31:0]       br_taken_cnt;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] modelPc;
    logic [31:0] modelBr;
    logic [31:0] modelTaken;

    typedef struct {
        logic        rst;
        logic        fEn;
        logic        isBranch;
        logic        bJump;
        logic        isJ;
        logic        isJR;
        logic [31:0] dPc;
        logic [15:0] imm16;
        logic [25:0] imm26;
        logic [31:0] rd1;
        logic [31:0] expPc;
    } vec_t;

    f_next_pc #(.PC_RESET(PC_RESET), .IM_AW(IM_AW)) dut (
        .clk(clk), .reset(reset), .F_en(F_en), .D_PC(D_PC), .D_imm16(D_imm16),
        .D_imm26(D_imm26), .Is_Branch(Is_Branch), .B_jump(B_jump), .Is_J(Is_J),
        .Is_JR(Is_JR), .D_RD1(D_RD1), .F_PC(F_PC), .F_PC4(F_PC4),
        .F_IM_addr(F_IM_addr), .F_oor(F_oor), .F_misalign(F_misalign),
        .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic rst, input logic fEn, input logic isBranch,
                                   input logic bJump, input logic isJ, input logic isJR,
                                   input logic [31:0] dPc, input logic [15:0] imm16,
                                   input logic [25:0] imm26, input logic [31:0] rd1,
                                   input logic [31:0] expPc);
        vec_t v;
        v.rst = rst; v.fEn = fEn; v.isBranch = isBranch; v.bJump = bJump;
        v.isJ = isJ; v.isJR = isJR; v.dPc = dPc; v.imm16 = imm16;
        v.imm26 = imm26; v.rd1 = rd1; v.expPc = expPc;
        return v;
    endfunction

    // Reference model: the next PC derived directly from the redirect rules.
    task automatic modelStep(input vec_t v);
        longint signed off;
        if (v.rst) begin
            modelPc    = PC_RESET;
            modelBr    = 0;
            modelTaken = 0;
        end else if (v.fEn) begin
`ifdef F_BR_STAT_EN
            if (v.isBranch) begin
                modelBr = modelBr + 1;
                if (v.bJump) modelTaken = modelTaken + 1;
            end
`endif
            if (v.isJR) begin
                modelPc = v.rd1;
            end else if (v.isJ) begin
                modelPc = ((v.dPc + 32'd4) & 32'hF000_0000) | (32'(v.imm26) * 32'd4);
            end else if (v.bJump) begin
                off     = longint'($signed(v.imm16)) * 4;
                modelPc = 32'(longint'(v.dPc) + 4 + off);
            end else begin
                modelPc = modelPc + 32'd4;
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Compare every DUT output against the values implied by the model PC.
    task automatic checkOutput(input string tag);
        longint unsigned pcL;
        logic [31:0]     expAddr;
        logic            expOor;
        pcL     = longint'(modelPc);
        expOor  = (pcL < longint'(PC_RESET)) || (pcL >= longint'(PC_RESET) + 4 * (64'd1 << IM_AW));
        expAddr = ((modelPc - PC_RESET) / 4) % (32'd1 << IM_AW);
        checkVal({tag, ".F_PC"}, F_PC, modelPc);
        checkVal({tag, ".F_PC4"}, F_PC4, modelPc + 32'd4);
        checkVal({tag, ".F_IM_addr"}, 32'(F_IM_addr), expAddr);
        checkVal({tag, ".F_oor"}, 32'(F_oor), 32'(expOor));
        checkVal({tag, ".F_misalign"}, 32'(F_misalign), 32'((modelPc % 4) != 0));
        checkVal({tag, ".br_cnt"}, br_cnt, modelBr);
        checkVal({tag, ".br_taken_cnt"}, br_taken_cnt, modelTaken);
    endtask

    // Drive one vector away from the edge, clock it, and advance the model.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset = v.rst; F_en = v.fEn; Is_Branch = v.isBranch; B_jump = v.bJump;
        Is_J = v.isJ; Is_JR = v.isJR; D_PC = v.dPc; D_imm16 = v.imm16;
        D_imm26 = v.imm26; D_RD1 = v.rd1;
        @(posedge clk);
        #1;
        modelStep(v);
    endtask

    vec_t table_q[$];
    vec_t rv;

    initial begin
        reset = 1'b1; F_en = 1'b0; D_PC = '0; D_imm16 = '0; D_imm26 = '0;
        Is_Branch = 1'b0; B_jump = 1'b0; Is_J = 1'b0; Is_JR = 1'b0; D_RD1 = '0;
        modelPc = 'x; modelBr = 'x; modelTaken = 'x;

        // Directed table: expected PC after each edge, starting from reset.
        table_q.push_back(mkVec(1, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3000));
        table_q.push_back(mkVec(1, 1, 0, 0, 1, 0, 32'h0, 16'h0, 26'h5, 32'h0, 32'h3000));
        table_q.push_back(mkVec(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3004));
        table_q.push_back(mkVec(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3008));
        table_q.push_back(mkVec(0, 1, 1, 1, 0, 0, 32'h3008, 16'hFFFE, 26'h0, 32'h0, 32'h3004));
        table_q.push_back(mkVec(0, 1, 1, 1, 0, 0, 32'h3008, 16'h0003, 26'h0, 32'h0, 32'h3018));
        table_q.push_back(mkVec(0, 1, 1, 0, 0, 0, 32'h3008, 16'h0003, 26'h0, 32'h0, 32'h301C));
        table_q.push_back(mkVec(0, 1, 0, 0, 1, 0, 32'h3010, 16'h0, 26'h0000C10, 32'h0, 32'h3040));
        table_q.push_back(mkVec(0, 1, 0, 0, 1, 1, 32'h3010, 16'h0, 26'h0000C10, 32'h3100, 32'h3100));
        table_q.push_back(mkVec(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3104));
        table_q.push_back(mkVec(0, 0, 1, 1, 0, 0, 32'h3008, 16'h0003, 26'h0, 32'h0, 32'h3104));
        table_q.push_back(mkVec(0, 0, 1, 1, 0, 0, 32'h3008, 16'h0003, 26'h0, 32'h0, 32'h3104));
        table_q.push_back(mkVec(0, 0, 1, 1, 0, 0, 32'h3008, 16'h0003, 26'h0, 32'h0, 32'h3104));
        table_q.push_back(mkVec(0, 1, 1, 1, 0, 0, 32'h3008, 16'h0003, 26'h0, 32'h0, 32'h3018));
        table_q.push_back(mkVec(0, 1, 0, 0, 0, 1, 32'h0, 16'h0, 26'h0, 32'h3002, 32'h3002));
        table_q.push_back(mkVec(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3006));
        table_q.push_back(mkVec(0, 1, 0, 0, 0, 1, 32'h0, 16'h0, 26'h0, 32'h6FFC, 32'h6FFC));
        table_q.push_back(mkVec(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h7000));

        for (int i = 0; i < table_q.size(); i++) begin
            applyStimulus(table_q[i]);
            checkVal($sformatf("vec%0d.expPc", i), F_PC, table_q[i].expPc);
            checkOutput($sformatf("vec%0d", i));
        end

        // Wrap from the top of the address space, then reset while a jump is present.
        applyStimulus(mkVec(0, 1, 0, 0, 0, 1, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0));
        checkVal("wrapTop.F_oor", 32'(F_oor), 32'd1);
        checkOutput("wrapTop");
        applyStimulus(mkVec(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0));
        checkVal("wrapZero.F_PC", F_PC, 32'h0);
        checkOutput("wrapZero");
        applyStimulus(mkVec(0, 1, 1, 1, 0, 0, 32'h0, 16'h0010, 26'h0, 32'h0, 32'h0));
        checkOutput("preReset");
        applyStimulus(mkVec(1, 1, 1, 1, 1, 1, 32'h1234, 16'h7, 26'h99, 32'h5000, 32'h0));
        checkVal("midReset.F_PC", F_PC, PC_RESET);
        checkOutput("midReset");

        // Randomized traffic checked against the reference model.
        for (int n = 0; n < 400; n++) begin
            rv.rst      = ($urandom_range(0, 59) == 0);
            rv.fEn      = ($urandom_range(0, 9) < 8);
            rv.isBranch = ($urandom_range(0, 3) == 0);
            rv.bJump    = rv.isBranch && ($urandom_range(0, 1) == 1);
            rv.isJ      = ($urandom_range(0, 6) == 0);
            rv.isJR     = ($urandom_range(0, 7) == 0);
            rv.dPc      = ($urandom_range(0, 1) == 1) ? modelPc - 32'd4 : $urandom();
            rv.imm16    = 16'($urandom());
            rv.imm26    = 26'($urandom());
            rv.rd1      = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 : $urandom();
            rv.expPc    = '0;
            applyStimulus(rv);
            checkOutput($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
